// File: rtl/pcie_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_rx_pkg
// Description : Gen1/Gen2 framing symbols and packet-context encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_rx_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  localparam int DLLP_LEN = 6;

  typedef logic [1:0] ctx_t;
  localparam ctx_t CTX_IDLE = 2'd0;
  localparam ctx_t CTX_TLP  = 2'd1;
  localparam ctx_t CTX_DLLP = 2'd2;

endpackage : pcie_rx_pkg
`default_nettype wire

// File: rtl/frame_byte_classifier.sv
`default_nettype none
// ============================================================================
// Module      : frame_byte_classifier
// Description : Combinational framing decision for one byte given the
//               packet context left by the previous byte.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_byte_classifier
  import pcie_rx_pkg::*;
#(
  parameter int DLLP_LEN = pcie_rx_pkg::DLLP_LEN
) (
  input  logic [7:0] byte_in,
  input  logic       k_in,
  input  ctx_t       state_in,
  input  logic [2:0] cnt_in,
  output logic       tlp_start,
  output logic       dllp_start,
  output logic       tlp_end,
  output logic       dllp_end,
  output logic       edb_out,
  output logic       valid,
  output logic       err,
  output ctx_t       state_out,
  output logic [2:0] cnt_out
);

  always_comb begin
    tlp_start  = 1'b0;
    dllp_start = 1'b0;
    tlp_end    = 1'b0;
    dllp_end   = 1'b0;
    edb_out    = 1'b0;
    valid      = 1'b0;
    err        = 1'b0;
    state_out  = state_in;
    cnt_out    = cnt_in;

    case (state_in)
      CTX_IDLE: begin
        if (k_in) begin
          if (byte_in == STP) begin
            tlp_start = 1'b1;
            state_out = CTX_TLP;
          end else if (byte_in == SDP) begin
            dllp_start = 1'b1;
            cnt_out    = 3'd0;
            state_out  = CTX_DLLP;
          end else if (!(byte_in == COM || byte_in == SKP || byte_in == IDL)) begin
            err = 1'b1;
          end
        end
      end
      CTX_TLP: begin
        if (!k_in) begin
          valid = 1'b1;
        end else begin
          state_out = CTX_IDLE;
          if (byte_in == END)      tlp_end = 1'b1;
          else if (byte_in == EDB) edb_out = 1'b1;
          else                     err     = 1'b1;
        end
      end
      CTX_DLLP: begin
        if (!k_in) begin
          valid = 1'b1;
          if (cnt_in != 3'd7) cnt_out = cnt_in + 3'd1;
        end else begin
          state_out = CTX_IDLE;
          // An END arriving with the wrong payload count is a framing error, not a DLLP end
          if (byte_in == END && cnt_in == 3'(DLLP_LEN)) dllp_end = 1'b1;
          else                                          err      = 1'b1;
        end
      end
      default: state_out = CTX_IDLE;
    endcase
  end

endmodule : frame_byte_classifier
`default_nettype wire

// File: rtl/lpif_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : lpif_rx_frame_decoder
// Description : Per-beat 8b/10b framing scan producing registered per-byte
//               markers, payload-valid flags and data for LPIF RX compaction.
// Revision    : 1.0 - initial release
// ============================================================================
module lpif_rx_frame_decoder
  import pcie_rx_pkg::*;
#(
  parameter int NBYTES   = 64,
  parameter int DLLP_LEN = pcie_rx_pkg::DLLP_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBYTES*8-1:0]   rxData,
  input  logic [NBYTES-1:0]     rxDataK,
  input  logic                  rxValid,
  input  logic                  linkUp,
  output logic [NBYTES-1:0]     tlpstart,
  output logic [NBYTES-1:0]     dllpstart,
  output logic [NBYTES-1:0]     tlpend,
  output logic [NBYTES-1:0]     dllpend,
  output logic [NBYTES-1:0]     edb,
  output logic [NBYTES-1:0]     packetValid,
  output logic [NBYTES*8-1:0]   packetData,
  output logic                  framingErr
);

  ctx_t              r_state;
  logic [2:0]        r_cnt;

  ctx_t              w_state [0:NBYTES];
  logic [2:0]        w_cnt   [0:NBYTES];
  logic [NBYTES-1:0] w_tlp_start;
  logic [NBYTES-1:0] w_dllp_start;
  logic [NBYTES-1:0] w_tlp_end;
  logic [NBYTES-1:0] w_dllp_end;
  logic [NBYTES-1:0] w_edb;
  logic [NBYTES-1:0] w_valid;
  logic [NBYTES-1:0] w_err;

  assign w_state[0] = r_state;
  assign w_cnt[0]   = r_cnt;

  // Context ripples byte 0 -> NBYTES-1 so several packets can share a beat
  generate
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      frame_byte_classifier #(
        .DLLP_LEN (DLLP_LEN)
      ) u_cls (
        .byte_in    (rxData[8*b +: 8]),
        .k_in       (rxDataK[b]),
        .state_in   (w_state[b]),
        .cnt_in     (w_cnt[b]),
        .tlp_start  (w_tlp_start[b]),
        .dllp_start (w_dllp_start[b]),
        .tlp_end    (w_tlp_end[b]),
        .dllp_end   (w_dllp_end[b]),
        .edb_out    (w_edb[b]),
        .valid      (w_valid[b]),
        .err        (w_err[b]),
        .state_out  (w_state[b+1]),
        .cnt_out    (w_cnt[b+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CTX_IDLE;
      r_cnt       <= 3'd0;
      tlpstart    <= '0;
      dllpstart   <= '0;
      tlpend      <= '0;
      dllpend     <= '0;
      edb         <= '0;
      packetValid <= '0;
      packetData  <= '0;
      framingErr  <= 1'b0;
    end else begin
      packetData <= rxData;
      if (linkUp && rxValid) begin
        r_state     <= w_state[NBYTES];
        r_cnt       <= w_cnt[NBYTES];
        tlpstart    <= w_tlp_start;
        dllpstart   <= w_dllp_start;
        tlpend      <= w_tlp_end;
        dllpend     <= w_dllp_end;
        edb         <= w_edb;
        packetValid <= w_valid;
        framingErr  <= |w_err;
      end else begin
        // Link down drops any packet in flight; an idle beat just holds context
        if (!linkUp) begin
          r_state <= CTX_IDLE;
          r_cnt   <= 3'd0;
        end
        tlpstart    <= '0;
        dllpstart   <= '0;
        tlpend      <= '0;
        dllpend     <= '0;
        edb         <= '0;
        packetValid <= '0;
        framingErr  <= 1'b0;
      end
    end
  end

endmodule : lpif_rx_frame_decoder
`default_nettype wire

// File: tb/tb_lpif_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpif_rx_frame_decoder
// Description : Directed self-checking bench for the RX framing decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpif_rx_frame_decoder;

  logic         clk;
  logic         reset;
  logic [511:0] rxData;
  logic [63:0]  rxDataK;
  logic         rxValid;
  logic         linkUp;
  logic [63:0]  tlpstart, dllpstart, tlpend, dllpend, edb, packetValid;
  logic [511:0] packetData;
  logic         framingErr;

  int n_tests;
  int n_fail;

  lpif_rx_frame_decoder #(
    .NBYTES   (64),
    .DLLP_LEN (6)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .rxData      (rxData),
    .rxDataK     (rxDataK),
    .rxValid     (rxValid),
    .linkUp      (linkUp),
    .tlpstart    (tlpstart),
    .dllpstart   (dllpstart),
    .tlpend      (tlpend),
    .dllpend     (dllpend),
    .edb         (edb),
    .packetValid (packetValid),
    .packetData  (packetData),
    .framingErr  (framingErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beat();
    rxData  = '0;
    rxDataK = '0;
  endtask

  task automatic put(input int idx, input logic [7:0] v, input logic kk);
    rxData[idx*8 +: 8] = v;
    rxDataK[idx]       = kk;
  endtask

  task automatic payload(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) put(i, 8'(i + 8'h30), 1'b0);
  endtask

  task automatic check_markers(input string tag, input logic [63:0] e_ts, input logic [63:0] e_ds,
                               input logic [63:0] e_te, input logic [63:0] e_de,
                               input logic [63:0] e_edb, input logic [63:0] e_pv,
                               input logic e_err);
    check({tag, ".tlpstart"},    {448'd0, tlpstart},    {448'd0, e_ts});
    check({tag, ".dllpstart"},   {448'd0, dllpstart},   {448'd0, e_ds});
    check({tag, ".tlpend"},      {448'd0, tlpend},      {448'd0, e_te});
    check({tag, ".dllpend"},     {448'd0, dllpend},     {448'd0, e_de});
    check({tag, ".edb"},         {448'd0, edb},         {448'd0, e_edb});
    check({tag, ".packetValid"}, {448'd0, packetValid}, {448'd0, e_pv});
    check({tag, ".framingErr"},  {511'd0, framingErr},  {511'd0, e_err});
  endtask

  logic [511:0] sent;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    rxValid = 1'b0;
    linkUp  = 1'b0;
    clear_beat();
    step();
    step();
    check_markers("reset", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    check("reset.packetData", packetData, 512'd0);

    reset   = 1'b1;
    linkUp  = 1'b1;
    rxValid = 1'b1;

    // TLP inside one beat
    clear_beat();
    put(0, 8'hFB, 1'b1);
    payload(1, 19);
    put(20, 8'hFD, 1'b1);
    sent = rxData;
    step();
    check_markers("tlp1", 64'h1, 64'h0, 64'h10_0000, 64'h0, 64'h0, 64'hF_FFFE, 1'b0);
    check("tlp1.packetData", packetData, sent);

    // DLLP then an empty TLP back to back
    clear_beat();
    put(0, 8'h5C, 1'b1);
    payload(1, 6);
    put(7, 8'hFD, 1'b1);
    put(8, 8'hFB, 1'b1);
    put(9, 8'hFD, 1'b1);
    step();
    check_markers("dllp_tlp", 64'h100, 64'h1, 64'h200, 64'h80, 64'h0, 64'h7E, 1'b0);

    // TLP straddling two beats with a bubble in between
    clear_beat();
    put(60, 8'hFB, 1'b1);
    payload(61, 63);
    step();
    check_markers("strad_a", 64'h1000_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0,
                  64'hE000_0000_0000_0000, 1'b0);
    rxValid = 1'b0;
    clear_beat();
    payload(0, 63);
    step();
    check_markers("bubble", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    rxValid = 1'b1;
    clear_beat();
    payload(0, 9);
    put(10, 8'hFD, 1'b1);
    step();
    check_markers("strad_b", 64'h0, 64'h0, 64'h400, 64'h0, 64'h0, 64'h3FF, 1'b0);

    // Nullified TLP
    clear_beat();
    put(0, 8'hFB, 1'b1);
    payload(1, 29);
    put(30, 8'hFE, 1'b1);
    step();
    check_markers("edb", 64'h1, 64'h0, 64'h0, 64'h0, 64'h4000_0000, 64'h3FFF_FFFE, 1'b0);

    // Short DLLP, then a TLP later in the same beat
    clear_beat();
    put(0, 8'h5C, 1'b1);
    payload(1, 5);
    put(6, 8'hFD, 1'b1);
    put(10, 8'hFB, 1'b1);
    put(11, 8'hFD, 1'b1);
    step();
    check_markers("bad_dllp", 64'h400, 64'h1, 64'h800, 64'h0, 64'h0, 64'h3E, 1'b1);

    // Ordered sets in idle are ignored; error pulse does not linger
    clear_beat();
    put(0, 8'hBC, 1'b1);
    put(1, 8'h1C, 1'b1);
    put(2, 8'h7C, 1'b1);
    step();
    check_markers("os_idle", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);

    // Unknown K symbol while idle
    clear_beat();
    put(5, 8'hF7, 1'b1);
    step();
    check("bad_k.framingErr", {511'd0, framingErr}, {511'd0, 1'b1});

    // linkUp drop mid-TLP
    clear_beat();
    put(0, 8'hFB, 1'b1);
    payload(1, 63);
    step();
    check("lnk_a.tlpstart", {448'd0, tlpstart}, {448'd0, 64'h1});
    linkUp = 1'b0;
    clear_beat();
    payload(0, 63);
    step();
    check_markers("lnk_down", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    linkUp = 1'b1;
    step();
    check("lnk_up.packetValid", {448'd0, packetValid}, 512'd0);

    // Async reset mid-TLP
    clear_beat();
    put(0, 8'hFB, 1'b1);
    payload(1, 63);
    step();
    check("rst_a.packetValid", {448'd0, packetValid}, {448'd0, 64'hFFFF_FFFF_FFFF_FFFE});
    #2;
    reset = 1'b0;
    #1;
    check_markers("rst_async", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    check("rst_async.packetData", packetData, 512'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_beat();
    payload(0, 63);
    step();
    check("rst_after.packetValid", {448'd0, packetValid}, 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lpif_rx_frame_decoder
`default_nettype wire

// File: doc/lpif_rx_frame_decoder.md
Name: lpif_rx_frame_decoder

Overview:
- Gen1/Gen2 (8b/10b) receive framing decoder.
- Sits directly upstream of the LPIF RX control/data-flow stage, which compacts valid bytes onto the pl_* interface.
- Scans each descrambled 64-byte beat for the K-symbols STP/SDP/END/EDB and tracks packet context across beats.
- Emits per-byte start/end/edb markers, per-byte payload-valid flags and registered data, in exactly the form the compaction stage consumes.

Parameters:
- NBYTES, 64, bytes per beat. Data width is NBYTES*8; all per-byte vectors are NBYTES wide.
- DLLP_LEN, 6, required DLLP payload byte count between SDP and END.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- rxData  in  512  descrambled byte stream; byte b = rxData[8b+7:8b], byte 0 first on the wire.
- rxDataK  in  64  K-symbol flag per byte.
- rxValid  in  1  beat valid; when low the beat is ignored.
- linkUp  in  1  LTSSM in L0; when low, decoder is held idle.
- tlpstart  out  64  marker at the STP byte position.
- dllpstart  out  64  marker at the SDP byte position.
- tlpend  out  64  marker at the END byte closing a TLP.
- dllpend  out  64  marker at the END byte closing a DLLP.
- edb  out  64  marker at the EDB byte (nullified TLP).
- packetValid  out  64  1 = payload byte inside a packet.
- packetData  out  512  registered copy of rxData.
- framingErr  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, reset=0): all outputs 0; context state = IDLE; dllpCnt = 0.
- Latency: one clock. Outputs are registered from the combinational scan of the current beat plus the registered context state.
- Context states: IDLE, IN_TLP, IN_DLLP. The state is carried byte-to-byte within a beat, then registered at the end of the beat.
- Per-byte rules, applied byte 0 to NBYTES-1 in order:
  - IDLE:
    - K=1 and byte=FB: tlpstart[b]=1, go to IN_TLP.
    - K=1 and byte=5C: dllpstart[b]=1, dllpCnt=0, go to IN_DLLP.
    - K=0 (logical idle), or K=1 and byte=BC/1C/7C (COM/SKP/IDL): ignored, packetValid=0.
    - Any other K byte: framingErr.
  - IN_TLP:
    - K=0: packetValid[b]=1.
    - K=1 and byte=FD: tlpend[b]=1, go to IDLE.
    - K=1 and byte=FE: edb[b]=1, go to IDLE.
    - Any other K byte: framingErr, go to IDLE; the packet is not marked ended.
  - IN_DLLP:
    - K=0: packetValid[b]=1, dllpCnt++ (3-bit, saturating at 7).
    - K=1 and byte=FD: if dllpCnt==DLLP_LEN then dllpend[b]=1, else framingErr; go to IDLE either way.
    - Any other K byte: framingErr, go to IDLE.
- Framing bytes always have packetValid=0. The downstream stage relies on this to fold the markers onto adjacent payload bytes.
- Several packets per beat are allowed, e.g. END then STP in consecutive bytes.
- Packets may straddle beats. State and dllpCnt persist while rxValid=0.
- rxValid=0: marker and valid outputs are 0 next cycle; packetData is still registered; state is held.
- linkUp=0: state forced to IDLE, dllpCnt=0, markers/valid outputs 0 next cycle, framingErr not asserted. A packet in flight is silently dropped.
- framingErr is the OR of all per-byte errors in the beat, pulsed once. Decoding continues from IDLE at the byte after the error.
- Reset asserted mid-packet: immediate return to reset values.

Decomposition:
- Shared package (pcie_rx_pkg): symbol constants STP=8'hFB, SDP=8'h5C, END=8'hFD, EDB=8'hFE, COM=8'hBC, SKP=8'h1C, IDL=8'h7C; context-state enum; DLLP_LEN.
- One sub-module, frame_byte_classifier: purely combinational. Takes (byte, K, state_in, dllpCnt_in) and returns (markers, valid, err, state_out, dllpCnt_out). NBYTES copies are chained in a generate loop.

Test Plan:
- TLP within one beat: FB@0, K=0 payload bytes 1-19, FD@20, rest idle -> tlpstart[0]=1, packetValid[19:1]=all 1, tlpend[20]=1, everything else 0, one cycle after the input.
- Back-to-back DLLP then TLP: 5C@0, 6 data bytes, FD@7, FB@8, ... -> dllpstart[0], packetValid[6:1], dllpend[7], tlpstart[8]; framingErr=0.
- Straddling TLP: FB@60 with data bytes 61-63; next beat carries data bytes 0-9, FD@10, with an rxValid=0 bubble between the beats -> first beat packetValid[63:61], second beat packetValid[9:0], tlpend[10]; bubble cycle outputs all 0.
- Nullified TLP: FB@0, data, FE@30 -> edb[30]=1, tlpend=0.
- Bad DLLP length: 5C@0, 5 data bytes, FD@6 -> dllpend=0, framingErr pulse; a following STP@10 still yields tlpstart[10]=1.
- linkUp drop / async reset mid-TLP: linkUp drops after FB@0 -> next beat's data yields packetValid=0. reset=0 mid-TLP -> all outputs 0 immediately; after release, data without STP produces no valid bytes.
